// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader: FSM states,
// instruction width and the NOP word returned on any non-hit fetch.
package inst_rom_loader_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch port and loader stream bundled together. The master side belongs to
// the core and the image source; the slave side belongs to the ROM.
interface inst_rom_loader_if #(
  parameter int DEPTH_LOG2 = 10
);
  import inst_rom_loader_pkg::*;

  logic                rom_en;
  logic [31:0]         rom_addr;
  logic [INSTR_W-1:0]  rom_data;

  logic                ld_start;
  logic [DEPTH_LOG2:0] ld_len;
  logic                ld_valid;
  logic [INSTR_W-1:0]  ld_data;
  logic                ld_ready;
  logic                ld_done;
  logic                ld_err;

  modport master (
    output rom_en, rom_addr, ld_start, ld_len, ld_valid, ld_data,
    input  rom_data, ld_ready, ld_done, ld_err
  );

  modport slave (
    input  rom_en, rom_addr, ld_start, ld_len, ld_valid, ld_data,
    output rom_data, ld_ready, ld_done, ld_err
  );

endinterface

// File: rtl/inst_rom_loader_rom_array.sv
// Word memory with one synchronous write port and one asynchronous read port,
// so a fetch returns its word in the same cycle the address is presented.
module inst_rom_loader_rom_array
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [INSTR_W-1:0]    wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [INSTR_W-1:0]    rdata
);

  logic [INSTR_W-1:0] mem [1 << DEPTH_LOG2];

  // NOTE: the array has no reset; contents survive a system reset, and
  // resetting a RAM would prevent mapping it onto memory macros.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port. Loads an image over a
// valid/ready stream and holds the core in reset until the image is complete.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int RESET_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  inst_rom_loader_if.slave    bus,
  output logic                fetch_oob,
  output logic                cpu_reset
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t              state, state_nx;
  logic [DEPTH_LOG2:0] len;
  logic [DEPTH_LOG2:0] wptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                ld_done_q;
  logic                ld_err_q;
  logic                ld_err_nx;
  logic                ld_ready_c;
  logic                len_ok;
  logic                accept;
  logic                last_word;
  logic                addr_hi_zero;
  logic [INSTR_W-1:0]  rd_data;
  logic [1:0]          unused_byte_offset;

  assign unused_byte_offset = bus.rom_addr[1:0];

  assign len_ok       = (bus.ld_len != '0) && (bus.ld_len <= DEPTH_W);
  assign ld_ready_c   = (state == LOAD);
  assign accept       = bus.ld_valid && ld_ready_c;
  assign last_word    = (wptr == len - (DEPTH_LOG2+1)'(1));
  assign addr_hi_zero = (bus.rom_addr[31:DEPTH_LOG2+2] == '0);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    ld_err_nx = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (bus.ld_start) begin
          if (len_ok) state_nx  = LOAD;
          else        ld_err_nx = 1'b1;
        end
      end
      LOAD: begin
        if (accept && last_word) state_nx = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      wptr      <= '0;
      hold_cnt  <= '0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
      fetch_oob <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_nx;
      ld_err_q  <= ld_err_nx;
      ld_done_q <= (state == HOLD) && (state_nx == RUN);
      cpu_reset <= (state_nx != RUN);

      // A reload from RUN restarts the write pointer exactly like a boot load.
      if (state != LOAD && state_nx == LOAD) begin
        len  <= bus.ld_len;
        wptr <= '0;
      end else if (accept) begin
        wptr <= wptr + (DEPTH_LOG2+1)'(1);
      end

      if (state == LOAD && state_nx == HOLD) begin
        hold_cnt <= HOLD_W'(RESET_HOLD - 1);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      if (state == RUN && bus.rom_en && !addr_hi_zero) begin
        fetch_oob <= 1'b1;
      end
    end
  end

  inst_rom_loader_rom_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_rom_array (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr[DEPTH_LOG2-1:0]),
    .wdata (bus.ld_data),
    .raddr (bus.rom_addr[DEPTH_LOG2+1:2]),
    .rdata (rd_data)
  );

  // Fetches outside RUN return NOP, so a fetch can never race a load write.
  assign bus.rom_data = (bus.rom_en && state == RUN && addr_hi_zero) ? rd_data : ZERO_WORD;
  assign bus.ld_ready = ld_ready_c;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: boot load, streaming with gaps, length
// errors, out-of-range fetches, aborted loads and reloads from RUN.
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset;
  logic fetch_oob;
  logic cpu_reset;
  int   total = 0;
  int   bad   = 0;

  inst_rom_loader_if #(.DEPTH_LOG2(DL)) bus ();

  inst_rom_loader #(
    .DEPTH_LOG2 (DL),
    .RESET_HOLD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fetch_oob (fetch_oob),
    .cpu_reset (cpu_reset)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [DL:0] len);
    bus.ld_start = 1'b1;
    bus.ld_len   = len;
    step();
    bus.ld_start = 1'b0;
  endtask

  task automatic feed(input logic v, input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_data  = d;
    step();
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (cpu_reset !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (cpu_reset !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: cpu_reset=%b want 0 within 20 cycles", tag, cpu_reset);
    end else if (bus.ld_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: ld_done=%b want 1 in first RUN cycle", tag, bus.ld_done);
    end
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] addr, input logic [31:0] want);
    bus.rom_en   = 1'b1;
    bus.rom_addr = addr;
    #1;
    total++;
    if (bus.rom_data !== want) begin
      bad++;
      $display("FAIL %s: addr=%h rom_data=%h want %h", tag, addr, bus.rom_data, want);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    bus.rom_en   = 1'b1;
    bus.rom_addr = 32'h0;
    #1;
    total++;
    if (bus.rom_data !== 32'h0)  begin bad++; $display("FAIL rst_rom_data: got %h want 0", bus.rom_data); end
    total++;
    if (cpu_reset !== 1'b1)      begin bad++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    total++;
    if (bus.ld_ready !== 1'b0)   begin bad++; $display("FAIL rst_ld_ready: got %b want 0", bus.ld_ready); end
    total++;
    if ({bus.ld_done, bus.ld_err, fetch_oob} !== 3'b000) begin
      bad++; $display("FAIL rst_flags: done/err/oob=%b want 000", {bus.ld_done, bus.ld_err, fetch_oob});
    end
    // Out-of-range fetch outside RUN must not set the sticky flag.
    bus.rom_addr = 32'h0000_1000;
    step();
    total++;
    if (fetch_oob !== 1'b0)      begin bad++; $display("FAIL idle_oob: got %b want 0", fetch_oob); end
    bus.rom_addr = 32'h0;
  endtask

  task automatic test_prime();
    logic [31:0] w [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    start_load(11'd4);
    for (int i = 0; i < 4; i++) feed(1'b1, w[i]);
    wait_run("prime");
  endtask

  task automatic test_stream();
    logic [31:0] w [3] = '{32'h3401_1100, 32'h3402_0020, 32'h3403_ff00};
    start_load(11'd3);
    total++;
    if ({cpu_reset, bus.ld_ready} !== 2'b11) begin
      bad++; $display("FAIL stream_enter: cpu_reset/ld_ready=%b want 11", {cpu_reset, bus.ld_ready});
    end
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = w[i];
      step();
    end
    bus.ld_valid = 1'b0;
    total++;
    if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL stream_ready_drop: got %b want 0", bus.ld_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({cpu_reset, bus.ld_done} !== 2'b10) begin
        bad++; $display("FAIL stream_hold%0d: cpu_reset/ld_done=%b want 10", i, {cpu_reset, bus.ld_done});
      end
    end
    step();
    total++;
    if ({cpu_reset, bus.ld_done} !== 2'b01) begin
      bad++; $display("FAIL stream_release: cpu_reset/ld_done=%b want 01", {cpu_reset, bus.ld_done});
    end
    step();
    total++;
    if (bus.ld_done !== 1'b0) begin bad++; $display("FAIL stream_done_pulse: got %b want 0", bus.ld_done); end
    expect_fetch("stream_fetch0", 32'h0,  32'h3401_1100);
    expect_fetch("stream_fetch4", 32'h4,  32'h3402_0020);
    expect_fetch("stream_fetch8", 32'h8,  32'h3403_ff00);
    expect_fetch("stream_fetch12", 32'hC, 32'h4444_4444);
    expect_fetch("stream_byte_off", 32'h6, 32'h3402_0020);
    bus.rom_en = 1'b0;
    #1;
    total++;
    if (bus.rom_data !== 32'h0) begin bad++; $display("FAIL stream_en_low: got %h want 0", bus.rom_data); end
  endtask

  task automatic test_valid_toggle();
    start_load(11'd3);
    feed(1'b1, 32'hAAAA_0001);
    feed(1'b0, 32'hDEAD_0001);
    feed(1'b1, 32'hAAAA_0002);
    total++;
    if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL toggle_ready_mid: got %b want 1", bus.ld_ready); end
    feed(1'b0, 32'hDEAD_0002);
    feed(1'b1, 32'hAAAA_0003);
    total++;
    if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL toggle_ready_drop: got %b want 0", bus.ld_ready); end
    wait_run("toggle");
    expect_fetch("toggle_fetch0", 32'h0, 32'hAAAA_0001);
    expect_fetch("toggle_fetch4", 32'h4, 32'hAAAA_0002);
    expect_fetch("toggle_fetch8", 32'h8, 32'hAAAA_0003);
    expect_fetch("toggle_fetch12", 32'hC, 32'h4444_4444);
  endtask

  task automatic test_bad_len();
    logic [DL:0] lens [2] = '{11'd0, 11'd1025};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      start_load(lens[i]);
      total++;
      if ({bus.ld_err, bus.ld_ready, cpu_reset} !== 3'b101) begin
        bad++; $display("FAIL badlen_%0d: err/ready/cpu_reset=%b want 101", lens[i], {bus.ld_err, bus.ld_ready, cpu_reset});
      end
      step();
      total++;
      if (bus.ld_err !== 1'b0) begin bad++; $display("FAIL badlen_pulse_%0d: got %b want 0", lens[i], bus.ld_err); end
    end
    // Full-depth length is the largest legal value.
    start_load(11'd1024);
    total++;
    if ({bus.ld_err, bus.ld_ready} !== 2'b01) begin
      bad++; $display("FAIL fulllen: err/ready=%b want 01", {bus.ld_err, bus.ld_ready});
    end
    apply_reset();
  endtask

  task automatic test_abort();
    start_load(11'd3);
    feed(1'b1, 32'hC0C0_0000);
    feed(1'b1, 32'hC1C1_0001);
    apply_reset();
    #1;
    total++;
    if ({bus.ld_ready, cpu_reset} !== 2'b01) begin
      bad++; $display("FAIL abort_state: ready/cpu_reset=%b want 01", {bus.ld_ready, cpu_reset});
    end
    expect_fetch("abort_fetch_idle", 32'h4, 32'h0);
    start_load(11'd1);
    feed(1'b1, 32'h0000_0000);
    wait_run("abort_reload");
    expect_fetch("abort_fetch0", 32'h0, 32'h0000_0000);
    expect_fetch("abort_fetch4", 32'h4, 32'hC1C1_0001);
    expect_fetch("abort_fetch8", 32'h8, 32'hAAAA_0003);
  endtask

  task automatic test_oob_and_reload();
    expect_fetch("oob_data", 32'h0000_1000, 32'h0);
    total++;
    if (fetch_oob !== 1'b0) begin bad++; $display("FAIL oob_before: got %b want 0", fetch_oob); end
    step();
    total++;
    if (fetch_oob !== 1'b1) begin bad++; $display("FAIL oob_set: got %b want 1", fetch_oob); end
    expect_fetch("oob_inrange", 32'h4, 32'hC1C1_0001);
    step();
    total++;
    if (fetch_oob !== 1'b1) begin bad++; $display("FAIL oob_sticky: got %b want 1", fetch_oob); end
    start_load(11'd0);
    total++;
    if ({bus.ld_err, cpu_reset} !== 2'b10) begin
      bad++; $display("FAIL run_badlen: err/cpu_reset=%b want 10", {bus.ld_err, cpu_reset});
    end
    start_load(11'd2);
    total++;
    if ({cpu_reset, bus.ld_ready, bus.rom_data} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL run_reload: cpu_reset=%b ready=%b rom_data=%h want 1 1 0", cpu_reset, bus.ld_ready, bus.rom_data);
    end
    apply_reset();
    #1;
    total++;
    if (fetch_oob !== 1'b0) begin bad++; $display("FAIL oob_clear: got %b want 0", fetch_oob); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rom_en   = 1'b0;
    bus.rom_addr = 32'h0;
    bus.ld_start = 1'b0;
    bus.ld_len   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0;
    step();
    test_reset();
    test_prime();
    test_stream();
    test_valid_toggle();
    test_bad_len();
    test_abort();
    test_oob_and_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
